// File: rtl/uart_wb_host.sv
// uart_wb_host
//   Bus initiator for the UART register port. A single read or write
//   command from the core becomes one strobed bus transaction:
//     - stb is raised.
//     - After a setup hold, wb_clk is raised.
//     - The bus waits for ack, drops wb_clk, then waits for ack to fall.
//     - stb is dropped and a one-cycle response is returned.
//   Only one transaction is in flight at a time. An ack timeout in the
//   strobe or release phase aborts the transaction with rsp_err=1.
//
// Ports
//   clk, reset                     system clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only while idle)
//   cmd_write, cmd_addr, cmd_wdata command fields, sampled only at accept
//   rsp_valid, rsp_rdata, rsp_err  one-cycle response pulse; data and error
//                                  hold until the next response
//   wb_stb, wb_clk, wb_we          bus strobe, phase and direction
//                                  (wb_we: 1 = read, 0 = write)
//   wb_addr, wb_data_out           registered address and write data
//   wb_data_in, wb_ack             slave read data and acknowledge
//
// Every output is a register.
module uart_wb_host #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned SETUP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [1:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       wb_stb,
  output logic       wb_clk,
  output logic       wb_we,
  output logic [1:0] wb_addr,
  output logic [7:0] wb_data_out,
  input  logic [7:0] wb_data_in,
  input  logic       wb_ack
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // The shared counter is compared against "last cycle" values. The abort
  // and the wb_clk rise therefore land exactly N cycles after the phase is
  // entered. The counter never wraps.
  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0] SETUP_LAST   = 10'(SETUP_CYCLES - 1);

  state_t     state_r, state_next_s;
  logic [9:0] cnt_r, cnt_next_s;
  logic [7:0] rdata_r, rdata_next_s;
  logic       cmd_ready_next_s;
  logic       rsp_valid_next_s;
  logic [7:0] rsp_rdata_next_s;
  logic       rsp_err_next_s;
  logic       wb_stb_next_s;
  logic       wb_clk_next_s;
  logic       wb_we_next_s;
  logic [1:0] wb_addr_next_s;
  logic [7:0] wb_data_out_next_s;

  // Next-state and next-output logic. Every register holds by default.
  always_comb begin
    state_next_s       = state_r;
    cnt_next_s         = cnt_r;
    rdata_next_s       = rdata_r;
    cmd_ready_next_s   = cmd_ready;
    rsp_valid_next_s   = 1'b0;
    rsp_rdata_next_s   = rsp_rdata;
    rsp_err_next_s     = rsp_err;
    wb_stb_next_s      = wb_stb;
    wb_clk_next_s      = wb_clk;
    wb_we_next_s       = wb_we;
    wb_addr_next_s     = wb_addr;
    wb_data_out_next_s = wb_data_out;

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_next_s       = ST_SETUP;
          cnt_next_s         = 10'd0;
          cmd_ready_next_s   = 1'b0;
          wb_stb_next_s      = 1'b1;
          wb_clk_next_s      = 1'b0;
          wb_we_next_s       = ~cmd_write;
          wb_addr_next_s     = cmd_addr;
          wb_data_out_next_s = cmd_write ? cmd_wdata : 8'h00;
        end else begin
          cmd_ready_next_s = 1'b1;
        end
      end

      // Ack is deliberately ignored here, so a stale ack cannot shorten setup.
      ST_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_next_s  = ST_STROBE;
          cnt_next_s    = 10'd0;
          wb_clk_next_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r + 10'd1;
        end
      end

      ST_STROBE: begin
        if (wb_ack) begin
          state_next_s  = ST_RELEASE;
          cnt_next_s    = 10'd0;
          wb_clk_next_s = 1'b0;
          rdata_next_s  = wb_we ? wb_data_in : 8'h00;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_next_s     = ST_DONE;
          wb_clk_next_s    = 1'b0;
          wb_stb_next_s    = 1'b0;
          rsp_valid_next_s = 1'b1;
          rsp_err_next_s   = 1'b1;
          rsp_rdata_next_s = 8'h00;
        end else begin
          cnt_next_s = cnt_r + 10'd1;
        end
      end

      // The captured read data is published only when the response goes
      // out. rsp_rdata therefore keeps its value until the next response.
      ST_RELEASE: begin
        if (!wb_ack) begin
          state_next_s     = ST_DONE;
          wb_stb_next_s    = 1'b0;
          rsp_valid_next_s = 1'b1;
          rsp_err_next_s   = 1'b0;
          rsp_rdata_next_s = rdata_r;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_next_s     = ST_DONE;
          wb_clk_next_s    = 1'b0;
          wb_stb_next_s    = 1'b0;
          rsp_valid_next_s = 1'b1;
          rsp_err_next_s   = 1'b1;
          rsp_rdata_next_s = 8'h00;
        end else begin
          cnt_next_s = cnt_r + 10'd1;
        end
      end

      ST_DONE: begin
        state_next_s     = ST_IDLE;
        cnt_next_s       = 10'd0;
        cmd_ready_next_s = 1'b1;
      end

      default: begin
        state_next_s     = ST_IDLE;
        cnt_next_s       = 10'd0;
        cmd_ready_next_s = 1'b1;
        wb_stb_next_s    = 1'b0;
        wb_clk_next_s    = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset aborts any transaction silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 10'd0;
      rdata_r     <= 8'h00;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_err     <= 1'b0;
      wb_stb      <= 1'b0;
      wb_clk      <= 1'b0;
      wb_we       <= 1'b1;
      wb_addr     <= 2'd0;
      wb_data_out <= 8'h00;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      rdata_r     <= rdata_next_s;
      cmd_ready   <= cmd_ready_next_s;
      rsp_valid   <= rsp_valid_next_s;
      rsp_rdata   <= rsp_rdata_next_s;
      rsp_err     <= rsp_err_next_s;
      wb_stb      <= wb_stb_next_s;
      wb_clk      <= wb_clk_next_s;
      wb_we       <= wb_we_next_s;
      wb_addr     <= wb_addr_next_s;
      wb_data_out <= wb_data_out_next_s;
    end
  end

endmodule

// File: tb/tb_uart_wb_host.sv
// tb_uart_wb_host
//   Directed bench for uart_wb_host with TIMEOUT_CYCLES=16 and
//   SETUP_CYCLES=1. The slave model registers its ack: ack rises one cycle
//   after it samples stb & wb_clk high, and falls one cycle after it samples
//   wb_clk low. This gives the 5-cycle minimum latency from the accept edge
//   to the rsp_valid edge.
module tb_uart_wb_host;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       wb_stb;
  logic       wb_clk;
  logic       wb_we;
  logic [1:0] wb_addr;
  logic [7:0] wb_data_out;
  logic [7:0] wb_data_in;
  logic       wb_ack;

  int vectors     = 0;
  int miscompares = 0;
  int slave_mode  = 0;   // 0 normal, 1 never ack, 2 ack stuck high

  // Expected outputs in reset, packed in the same order as outs().
  localparam logic [23:0] RESET_OUTS =
    {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00};

  uart_wb_host #(.TIMEOUT_CYCLES(16), .SETUP_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_stb(wb_stb), .wb_clk(wb_clk), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data_out(wb_data_out), .wb_data_in(wb_data_in), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  // Registered slave acknowledge model.
  always @(posedge clk) begin
    if (reset) begin
      wb_ack <= 1'b0;
    end else begin
      case (slave_mode)
        1:       wb_ack <= 1'b0;
        2:       wb_ack <= wb_ack | (wb_stb & wb_clk);
        default: wb_ack <= wb_stb & wb_clk;
      endcase
    end
  end

  function automatic logic [23:0] outs();
    return {cmd_ready, rsp_valid, rsp_err, rsp_rdata, wb_stb, wb_clk, wb_we,
            wb_addr, wb_data_out};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [1:0] a,
                       input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
  endtask

  // Steps until rsp_valid is seen. lat counts edges after the accept edge;
  // rise records the step at which wb_clk was first high.
  task automatic wait_rsp(output int lat, output int rise);
    lat  = 0;
    rise = 0;
    do begin
      step();
      lat++;
      if (wb_clk === 1'b1 && rise == 0) rise = lat;
    end while (rsp_valid !== 1'b1 && lat < 64);
    if (rsp_valid !== 1'b1) check_val("rsp_wait", 32'(rsp_valid), 32'd1);
  endtask

  int lat, rise, bad, pulses;

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = 2'd0;
    cmd_wdata  = 8'h00;
    wb_data_in = 8'h00;
    repeat (3) step();
    check_val("reset_outs", 32'(outs()), 32'(RESET_OUTS));
    reset = 1'b0;
    step();

    // Write: addr 0, data 0x41.
    issue(1'b1, 2'd0, 8'h41);
    check_val("wr_stb", 32'(wb_stb), 32'd1);
    check_val("wr_clk_low", 32'(wb_clk), 32'd0);
    check_val("wr_we", 32'(wb_we), 32'd0);
    check_val("wr_data", 32'(wb_data_out), 32'h41);
    check_val("wr_ready", 32'(cmd_ready), 32'd0);
    wait_rsp(lat, rise);
    check_val("wr_latency", 32'(lat), 32'd5);
    check_val("wr_err", 32'(rsp_err), 32'd0);
    check_val("wr_stb_done", 32'(wb_stb), 32'd0);
    pulses = 0;
    repeat (3) begin
      step();
      if (rsp_valid) pulses++;
    end
    check_val("wr_pulses", 32'(pulses), 32'd0);
    check_val("wr_ready_back", 32'(cmd_ready), 32'd1);

    // Read: addr 1, the slave returns 0x5A.
    wb_data_in = 8'h5A;
    issue(1'b0, 2'd1, 8'hFF);
    check_val("rd_we", 32'(wb_we), 32'd1);
    check_val("rd_data_out", 32'(wb_data_out), 32'h00);
    check_val("rd_addr", 32'(wb_addr), 32'd1);
    wait_rsp(lat, rise);
    check_val("rd_latency", 32'(lat), 32'd5);
    check_val("rd_rdata", 32'(rsp_rdata), 32'h5A);
    check_val("rd_err", 32'(rsp_err), 32'd0);
    step();
    check_val("rd_pulse_end", 32'(rsp_valid), 32'd0);
    check_val("rd_rdata_hold", 32'(rsp_rdata), 32'h5A);

    // Strobe timeout: the slave never acks.
    slave_mode = 1;
    issue(1'b1, 2'd2, 8'h10);
    wait_rsp(lat, rise);
    check_val("to_rise", 32'(rise), 32'd1);
    check_val("to_after_rise", 32'(lat - rise), 32'd16);
    check_val("to_err", 32'(rsp_err), 32'd1);
    check_val("to_stb_clk", 32'({wb_stb, wb_clk}), 32'd0);
    check_val("to_rdata", 32'(rsp_rdata), 32'h00);
    step();

    // Release timeout: ack stays high after wb_clk falls (read, data 0x33).
    slave_mode = 2;
    wb_data_in = 8'h33;
    issue(1'b0, 2'd1, 8'h00);
    wait_rsp(lat, rise);
    check_val("rel_latency", 32'(lat), 32'd19);
    check_val("rel_err", 32'(rsp_err), 32'd1);
    check_val("rel_stb", 32'(wb_stb), 32'd0);
    check_val("rel_rdata", 32'(rsp_rdata), 32'h00);
    slave_mode = 0;
    step();
    step();

    // Back-to-back: cmd_valid held high, write addr 2 then addr 0.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 2'd2;
    cmd_wdata = 8'h77;
    step();
    check_val("b2b_first_addr", 32'(wb_addr), 32'd2);
    cmd_addr  = 2'd0;
    cmd_wdata = 8'h12;
    bad = 0;
    lat = 0;
    do begin
      step();
      lat++;
      if (cmd_ready !== 1'b0 || wb_addr !== 2'd2 || wb_data_out !== 8'h77)
        bad++;
    end while (rsp_valid !== 1'b1 && lat < 64);
    check_val("b2b_busy_hold", 32'(bad), 32'd0);
    check_val("b2b_first_latency", 32'(lat), 32'd5);
    step();
    check_val("b2b_ready_gap", 32'({cmd_ready, wb_stb}), 32'b10);
    step();
    cmd_valid = 1'b0;
    check_val("b2b_second_addr", 32'(wb_addr), 32'd0);
    check_val("b2b_second_data", 32'(wb_data_out), 32'h12);
    check_val("b2b_second_stb", 32'({wb_stb, cmd_ready}), 32'b10);
    wait_rsp(lat, rise);
    check_val("b2b_second_latency", 32'(lat), 32'd5);
    check_val("b2b_second_err", 32'(rsp_err), 32'd0);
    step();

    // Reset asserted during the strobe phase.
    slave_mode = 1;
    issue(1'b1, 2'd0, 8'hA5);
    step();
    check_val("rst_in_strobe", 32'({wb_stb, wb_clk}), 32'b11);
    reset = 1'b1;
    step();
    check_val("rst_mid_outs", 32'(outs()), 32'(RESET_OUTS));
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      step();
      if (rsp_valid) pulses++;
    end
    check_val("rst_no_rsp", 32'(pulses), 32'd0);
    check_val("rst_idle_outs", 32'(outs()), 32'(RESET_OUTS));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
